expr_eval: RTL and testbench

EXPR_EVAL -- requirements
Module: expr_eval

---
 rtl/expr_eval.sv | 118 +++++++++++
 tb/tb_expr_eval.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit expressions with + and * (mul binds tighter).
// One character per accepted cycle; the result is held until the consumer takes it.
module expr_eval (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] res,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        err
);

    typedef enum logic [1:0] {
        S_NUM  = 2'd0,
        S_OP   = 2'd1,
        S_SKIP = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] acc;
    logic [15:0] term;
    logic        mulp;

    logic        is_digit;
    logic        is_plus;
    logic        is_mul;
    logic        is_end;
    logic [15:0] dval;
    logic [15:0] prod;
    logic        take_in;
    logic        take_res;

    assign is_digit = (in >= 8'd48) && (in <= 8'd57);
    assign is_plus  = (in == 8'd43);
    assign is_mul   = (in == 8'd42);
    assign is_end   = (in == 8'd61);
    assign dval     = {8'd0, in - 8'd48};
    assign prod     = term * dval;

    // Input side: valid/ready transfer on the rising edge when both are high.
    // Output side: res/err are held while res_valid is high until res_ready.
    assign in_ready = (state != S_OUT);
    assign take_in  = in_valid && in_ready;
    assign take_res = res_valid && res_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_NUM;
            acc       <= 16'd0;
            term      <= 16'd0;
            mulp      <= 1'b0;
            res       <= 16'd0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_NUM: begin
                    if (take_in) begin
                        if (is_digit) begin
                            term  <= mulp ? prod : dval;
                            mulp  <= 1'b0;
                            state <= S_OP;
                        end else if (is_end) begin
                            res       <= 16'd0;
                            err       <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            state <= S_SKIP;
                        end
                    end
                end
                S_OP: begin
                    if (take_in) begin
                        if (is_plus) begin
                            acc   <= acc + term;
                            term  <= 16'd0;
                            state <= S_NUM;
                        end else if (is_mul) begin
                            mulp  <= 1'b1;
                            state <= S_NUM;
                        end else if (is_end) begin
                            res       <= acc + term;
                            err       <= 1'b0;
                            res_valid <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            state <= S_SKIP;
                        end
                    end
                end
                // Malformed input: swallow everything up to the terminator.
                S_SKIP: begin
                    if (take_in && is_end) begin
                        res       <= 16'd0;
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (take_res) begin
                        res_valid <= 1'b0;
                        acc       <= 16'd0;
                        term      <= 16'd0;
                        mulp      <= 1'b0;
                        state     <= S_NUM;
                    end
                end
                default: state <= S_NUM;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: directed scenarios plus random expressions checked
// against a string-level reference evaluator.
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] res;
    logic        res_valid;
    logic        res_ready;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [16:0] exp_q[$];

    expr_eval dut (
        .clk      (clk),
        .clr      (clr),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .res      (res),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference: {err, value} for a string ending in '=' with no other '='.
    function automatic logic [16:0] model(input string s);
        int          n;
        int unsigned sum;
        int unsigned prod;
        logic [7:0]  c;
        n = s.len() - 1;
        if (n < 1 || (n % 2) == 0) return {1'b1, 16'd0};
        sum  = 0;
        prod = 1;
        for (int i = 0; i < n; i++) begin
            c = s.getc(i);
            if (i % 2 == 0) begin
                if (c < 8'd48 || c > 8'd57) return {1'b1, 16'd0};
                prod = prod * (int'(c) - 48);
            end else if (c == 8'd43) begin
                sum  = sum + prod;
                prod = 1;
            end else if (c != 8'd42) begin
                return {1'b1, 16'd0};
            end
        end
        sum = sum + prod;
        return {1'b0, sum[15:0]};
    endfunction

    function automatic string gen_expr();
        string      s;
        string      pool;
        int         nd;
        int         pos;
        logic [7:0] ch;
        s    = "";
        pool = "0123456789+*a /#";
        nd   = $urandom_range(6, 1);
        for (int i = 0; i < nd; i++) begin
            ch = 8'd48 + 8'($urandom_range(9, 0));
            s  = $sformatf("%s%c", s, ch);
            if (i < nd - 1) s = {s, ($urandom_range(1, 0) == 1) ? "+" : "*"};
        end
        if ($urandom_range(4, 0) == 0) begin
            pos = $urandom_range(s.len() - 1, 0);
            s.putc(pos, pool.getc($urandom_range(pool.len() - 1, 0)));
        end
        return {s, "="};
    endfunction

    // Starts and ends on a falling edge; each char is accepted on the following rising edge.
    task automatic send_chars(input string s, input int gap_max);
        for (int i = 0; i < s.len(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                in_valid = 1'b0;
                in       = 8'($urandom_range(255, 0));
                @(negedge clk);
            end
            in       = s.getc(i);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; in = 8'd0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        n_cmp++; if (res !== 16'd0) begin n_fail++; $display("FAIL rst_res: got %0d want 0", res); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rv_after: got %b want 0", res_valid); end
    endtask

    task automatic test_precedence();
        res_ready = 1'b1;
        send_chars("1+2*3=", 0);
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL prec_rv: got %b want 1", res_valid); end
        n_cmp++; if (res !== 16'd7) begin n_fail++; $display("FAIL prec_res: got %0d want 7", res); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL prec_err: got %b want 0", err); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prec_in_ready_out: got %b want 0", in_ready); end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL prec_rv_one_cycle: got %b want 0", res_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL prec_in_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        send_chars("2*3*4+5=", 0);
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rv1: got %b want 1", res_valid); end
        n_cmp++; if (res !== 16'd29) begin n_fail++; $display("FAIL b2b_res1: got %0d want 29", res); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err1: got %b want 0", err); end
        // '9' is offered during the transfer cycle and must only be taken one cycle later.
        in = "9"; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_out: got %b want 0", in_ready); end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rv_drop: got %b want 0", res_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in = "=";
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rv2: got %b want 1", res_valid); end
        n_cmp++; if (res !== 16'd9) begin n_fail++; $display("FAIL b2b_res2: got %0d want 9", res); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err2: got %b want 0", err); end
        @(negedge clk);
    endtask

    task automatic test_errors();
        string bad[3];
        bad = '{"1++2=", "=", "a3="};
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_chars(bad[i], 0);
            n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL err_rv[%0d]: got %b want 1", i, res_valid); end
            n_cmp++; if (res !== 16'd0) begin n_fail++; $display("FAIL err_res[%0d]: got %0d want 0", i, res); end
            n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag[%0d]: got %b want 1", i, err); end
            @(negedge clk);
            send_chars("4=", 0);
            n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL recov_rv[%0d]: got %b want 1", i, res_valid); end
            n_cmp++; if (res !== 16'd4) begin n_fail++; $display("FAIL recov_res[%0d]: got %0d want 4", i, res); end
            n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL recov_err[%0d]: got %b want 0", i, err); end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        res_ready = 1'b1;
        send_chars("9*9*9*9*9*9=", 0);
        n_cmp++; if (res !== 16'd7153) begin n_fail++; $display("FAIL wrap_res: got %0d want 7153", res); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0", err); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        send_chars("8+1=", 0);
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (res_valid !== 1'b1 || res !== 16'd9 || err !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold[%0d]: got rv=%b res=%0d err=%b want rv=1 res=9 err=0", k, res_valid, res, err); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
            in = "5"; in_valid = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", res_valid); end
        @(negedge clk);
        in = "=";
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (res !== 16'd5 || err !== 1'b0) begin n_fail++; $display("FAIL bp_after: got res=%0d err=%b want res=5 err=0", res, err); end
        @(negedge clk);
        send_chars("8+1=", 4);
        n_cmp++; if (res_valid !== 1'b1 || res !== 16'd9 || err !== 1'b0)
            begin n_fail++; $display("FAIL bp_gaps: got rv=%b res=%0d err=%b want rv=1 res=9 err=0", res_valid, res, err); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        send_chars("5*", 0);
        #1 clr = 1'b1;
        #2 clr = 1'b0;
        @(negedge clk);
        send_chars("3=", 0);
        n_cmp++; if (res_valid !== 1'b1 || res !== 16'd3 || err !== 1'b0)
            begin n_fail++; $display("FAIL rmid_res: got rv=%b res=%0d err=%b want rv=1 res=3 err=0", res_valid, res, err); end
        @(negedge clk);
        res_ready = 1'b0;
        send_chars("7=", 0);
        n_cmp++; if (res_valid !== 1'b1 || res !== 16'd7) begin n_fail++; $display("FAIL rout_pre: got rv=%b res=%0d want rv=1 res=7", res_valid, res); end
        #1 clr = 1'b1;
        #1;
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rout_async: got %b want 0", res_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rout_in_ready: got %b want 1", in_ready); end
        #1 clr = 1'b0;
        @(negedge clk);
        res_ready = 1'b1;
        send_chars("2=", 0);
        n_cmp++; if (res_valid !== 1'b1 || res !== 16'd2 || err !== 1'b0)
            begin n_fail++; $display("FAIL rout_next: got rv=%b res=%0d err=%b want rv=1 res=2 err=0", res_valid, res, err); end
        @(negedge clk);
    endtask

    task automatic test_random();
        string       s;
        logic [16:0] e;
        int          h;
        for (int n = 0; n < 60; n++) begin
            s = gen_expr();
            exp_q.push_back(model(s));
            h = $urandom_range(3, 0);
            res_ready = (h == 0);
            send_chars(s, 2);
            e = exp_q.pop_front();
            n_cmp++; if (res_valid !== 1'b1 || res !== e[15:0] || err !== e[16])
                begin n_fail++; $display("FAIL rand[%0d] \"%s\": got rv=%b res=%0d err=%b want rv=1 res=%0d err=%b", n, s, res_valid, res, err, e[15:0], e[16]); end
            for (int k = 0; k < h; k++) begin
                @(negedge clk);
                n_cmp++; if (res_valid !== 1'b1 || res !== e[15:0])
                    begin n_fail++; $display("FAIL rand_hold[%0d]: got rv=%b res=%0d want rv=1 res=%0d", n, res_valid, res, e[15:0]); end
            end
            res_ready = 1'b1;
            @(negedge clk);
            n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rand_xfer[%0d]: got rv=%b want 0", n, res_valid); end
        end
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_precedence();
        test_back_to_back();
        test_errors();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
